// File: rtl/rv32f_wb_scoreboard_if.sv
// Bus bundle between FP decode/FPU/load-return and the FP writeback scoreboard.
// The master side is the pipeline that drives issue/completion requests; the slave side is the scoreboard.
interface rv32f_wb_scoreboard_if #(
    parameter int NUM_REGS = 32
);
    logic                issue_valid;
    logic [4:0]          issue_rs1;
    logic [4:0]          issue_rs2;
    logic [4:0]          issue_rd;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    logic                issue_wr_rd;
    logic                issue_stall;

    logic                fpu_done;
    logic [4:0]          fpu_rd;
    logic [31:0]         fpu_result;

    logic                ld_valid;
    logic [4:0]          ld_rd;
    logic [31:0]         ld_data;
    logic                ld_ready;

    logic                f_wen;
    logic [4:0]          f_rd;
    logic [31:0]         f_wdata;

    logic [NUM_REGS-1:0] pending;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_use_rs1, issue_use_rs2, issue_wr_rd,
        output fpu_done, fpu_rd, fpu_result,
        output ld_valid, ld_rd, ld_data,
        input  issue_stall, ld_ready, f_wen, f_rd, f_wdata, pending
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_use_rs1, issue_use_rs2, issue_wr_rd,
        input  fpu_done, fpu_rd, fpu_result,
        input  ld_valid, ld_rd, ld_data,
        output issue_stall, ld_ready, f_wen, f_rd, f_wdata, pending
    );
endinterface

// File: rtl/rv32f_wb_scoreboard.sv
// FP register scoreboard plus writeback arbiter: tracks pending destinations, stalls hazards,
// and merges FPU completions with FLW returns onto a single registered register-file write port.
module rv32f_wb_scoreboard #(
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    rv32f_wb_scoreboard_if.slave sb
);

    typedef enum logic [1:0] {
        WSRC_NONE = 2'd0,
        WSRC_FPU  = 2'd1,
        WSRC_HOLD = 2'd2,
        WSRC_LOAD = 2'd3
    } wsrc_e;

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic                hold_full_r;
    logic [4:0]          hold_rd_r;
    logic [31:0]         hold_data_r;
    logic                f_wen_r;
    logic [4:0]          f_rd_r;
    logic [31:0]         f_wdata_r;

    wsrc_e               wsrc_s;
    logic                ld_fire_s;
    logic                capture_s;
    logic                stall_s;
    logic                accept_s;
    logic                wen_s;
    logic [4:0]          wrd_s;
    logic [31:0]         wdata_s;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 5'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Hazard detection against registered pending bits only; an in-flight write is not bypassed.
    always_comb begin
        stall_s = 1'b0;
        if (sb.issue_valid) begin
            stall_s = (sb.issue_use_rs1 && (|(reg_onehot(sb.issue_rs1) & pending_r))) ||
                      (sb.issue_use_rs2 && (|(reg_onehot(sb.issue_rs2) & pending_r))) ||
                      (sb.issue_wr_rd   && (|(reg_onehot(sb.issue_rd)  & pending_r)));
        end else begin
            stall_s = 1'b0;
        end
        accept_s = sb.issue_valid && !stall_s;
    end

    // Writeback source arbitration: FPU cannot be back-pressured, so a colliding load is parked.
    always_comb begin
        wsrc_s    = WSRC_NONE;
        capture_s = 1'b0;
        ld_fire_s = sb.ld_valid && !hold_full_r;
        if (sb.fpu_done) begin
            wsrc_s    = WSRC_FPU;
            capture_s = ld_fire_s;
        end else if (hold_full_r) begin
            wsrc_s = WSRC_HOLD;
        end else if (ld_fire_s) begin
            wsrc_s = WSRC_LOAD;
        end else begin
            wsrc_s = WSRC_NONE;
        end
    end

    // Write-port data mux for the selected source.
    always_comb begin
        wen_s   = 1'b0;
        wrd_s   = 5'd0;
        wdata_s = 32'd0;
        case (wsrc_s)
            WSRC_FPU: begin
                wen_s   = 1'b1;
                wrd_s   = sb.fpu_rd;
                wdata_s = sb.fpu_result;
            end
            WSRC_HOLD: begin
                wen_s   = 1'b1;
                wrd_s   = hold_rd_r;
                wdata_s = hold_data_r;
            end
            WSRC_LOAD: begin
                wen_s   = 1'b1;
                wrd_s   = sb.ld_rd;
                wdata_s = sb.ld_data;
            end
            default: begin
                wen_s   = 1'b0;
                wrd_s   = 5'd0;
                wdata_s = 32'd0;
            end
        endcase
    end

    // Pending update: clear for the write leaving the port, then set so a new issue wins a tie.
    always_comb begin
        pending_nxt_s = pending_r;
        if (f_wen_r) begin
            pending_nxt_s = pending_nxt_s & ~reg_onehot(f_rd_r);
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (accept_s && sb.issue_wr_rd) begin
            pending_nxt_s = pending_nxt_s | reg_onehot(sb.issue_rd);
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // One-entry load hold buffer; it only fills while empty, since ld_ready gates the handshake.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hold_full_r <= 1'b0;
            hold_rd_r   <= 5'd0;
            hold_data_r <= 32'd0;
        end else if (capture_s) begin
            hold_full_r <= 1'b1;
            hold_rd_r   <= sb.ld_rd;
            hold_data_r <= sb.ld_data;
        end else if (wsrc_s == WSRC_HOLD) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            f_wen_r   <= 1'b0;
            f_rd_r    <= 5'd0;
            f_wdata_r <= 32'd0;
        end else begin
            f_wen_r   <= wen_s;
            f_rd_r    <= wrd_s;
            f_wdata_r <= wdata_s;
        end
    end

    assign sb.issue_stall = stall_s;
    assign sb.ld_ready    = ~hold_full_r;
    assign sb.f_wen       = f_wen_r;
    assign sb.f_rd        = f_rd_r;
    assign sb.f_wdata     = f_wdata_r;
    assign sb.pending     = pending_r;

endmodule

// File: doc/rv32f_wb_scoreboard.md
RV32F_WB_SCOREBOARD -- requirements
Module: rv32f_wb_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, giving the FP register count; the index width is 5 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1: reset is synchronous and active-low.
REQ-004 SHALL have port issue_valid, input, 1: decode presents an FP instruction.
REQ-005 SHALL have ports issue_rs1, issue_rs2 and issue_rd, inputs, 5 each: source and destination indices.
REQ-006 SHALL have ports issue_use_rs1, issue_use_rs2 and issue_wr_rd, inputs, 1 each: qualify the three indices.
REQ-007 SHALL have port issue_stall, output, 1: the instruction cannot issue this cycle.
REQ-008 SHALL have ports fpu_done (input, 1), fpu_rd (input, 5) and fpu_result (input, 32): FPU completion, which cannot be back-pressured.
REQ-009 SHALL have ports ld_valid (input, 1), ld_rd (input, 5), ld_data (input, 32) and ld_ready (output, 1): the FLW return path, a valid/ready handshake.
REQ-010 SHALL have ports f_wen (output, 1), f_rd (output, 5) and f_wdata (output, 32): the FP register-file write port.
REQ-011 SHALL have port pending, output, NUM_REGS: the scoreboard bits, for debug and hazard logic.

Function
REQ-012 SHALL set issue_stall combinationally when issue_valid=1 and any of the following holds: issue_use_rs1 and pending[issue_rs1]; issue_use_rs2 and pending[issue_rs2]; issue_wr_rd and pending[issue_rd]. The last case is the WAW stall.
REQ-013 SHALL drive issue_stall=0 whenever issue_valid=0.
REQ-014 SHALL treat an issue as accepted when issue_valid=1 and issue_stall=0; an accepted issue with issue_wr_rd=1 sets pending[issue_rd] at the next edge.
REQ-015 SHALL register the write port: f_wen, f_rd and f_wdata reflect the source selected in cycle N during cycle N+1.
REQ-016 SHALL select the write source in priority order: fpu_done, then the load hold buffer, then the direct load handshake (ld_valid & ld_ready).
REQ-017 SHALL contain a one-entry load hold buffer. A load handshake that occurs in a cycle with fpu_done=1 is captured into the buffer instead of being written.
REQ-018 SHALL drive ld_ready = ~hold_full, combinationally from registered state.
REQ-019 SHALL, when the hold buffer is full and fpu_done=0, write the buffered load and empty the buffer. A new ld handshake in that same cycle is not possible because ld_ready=0.
REQ-020 SHALL, when the hold buffer is full and fpu_done=1, write the FPU result and retain the buffer.
REQ-021 SHALL clear pending[f_rd] at the edge that ends any cycle with f_wen=1.
REQ-022 SHALL give set priority over clear when both target the same index at the same edge.
REQ-023 SHALL never skip a write: every fpu_done pulse and every ld handshake produces exactly one f_wen cycle, with the data unmodified.
REQ-024 SHALL keep writes in order for each source: loads are written in handshake order, and FPU results in done order.
REQ-025 SHALL use the registered pending state for stall decisions, with no bypass of an in-flight write. An instruction whose source is being written this cycle stalls one extra cycle.
REQ-026 SHALL permit f0, like any other index, to be marked pending and written; no index is hard-wired.

Reset
REQ-027 SHALL, when n_rst=0 at a rising edge, clear pending to 0, empty the hold buffer, and drive f_wen=0, f_rd=0 and f_wdata=0 from the next cycle.
REQ-028 SHALL discard any FPU or load data presented during a reset cycle; no write results from it.
REQ-029 SHALL drive ld_ready=1 and issue_stall=0 (given issue_valid=0) in the first cycle after reset is released.
REQ-030 SHALL drop in-flight writes and pending bits when reset is asserted mid-operation; no stale f_wen occurs after release.

Verification
REQ-031 SHALL pass this scenario: issue rd=5, then issue rs1=5 next cycle -> issue_stall=1. Then fpu_done with rd=5 and result 0x3F800000 -> f_wen=1, f_rd=5, f_wdata=0x3F800000 one cycle later. pending[5]=0 after that cycle, and the stall drops in the following cycle.
REQ-032 SHALL pass this scenario: fpu_done (rd=2, 0x40000000) and ld handshake (rd=3, 0x40400000) in the same cycle -> cycle+1 write f2=0x40000000, ld_ready=0. Cycle+2 write f3=0x40400000, ld_ready=1.
REQ-033 SHALL pass this scenario: hold buffer full and fpu_done held high for 3 cycles -> three FPU writes first, then the buffered load write, with ld_ready=0 throughout until the buffer empties.
REQ-034 SHALL pass this scenario: issue rd=7 while pending[7]=1 -> issue_stall=1 (WAW). Issue rd=7 with issue_wr_rd=0 -> no stall.
REQ-035 SHALL pass this scenario: pending[9]=1 and hold buffer full, then n_rst=0 for one cycle -> pending=0, f_wen=0, ld_ready=1, and no write to f9 ever appears.
REQ-036 SHALL pass this scenario: back-to-back ld handshakes on rd=1..4 with fpu_done=0 -> four consecutive f_wen cycles, in order, and ld_ready constantly 1.
